// File: rtl/jellyvl_etherneco_packet_rx_pkg.sv
// Etherneco framing constants and receive state encoding, shared by the rx and tx paths.
// Byte-oriented framing: preamble, SFD, 16-bit length, type, node, payload, CRC-32 FCS.
package jellyvl_etherneco_packet_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_LENGTH,
        ST_TYPE,
        ST_NODE,
        ST_PAYLOAD,
        ST_FCS,
        ST_ERROR
    } rx_state_t;

    localparam logic [7:0]  ETHERNECO_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETHERNECO_SFD       = 8'hd5;
    localparam logic [31:0] ETHERNECO_CRC_POLY  = 32'h04c11db7;
    localparam int          ETHERNECO_FCS_BYTES = 4;

endpackage

// File: rtl/jelly2_calc_crc.sv
// Running CRC, one DATA_WIDTH word per cke; in_update=0 restarts from all-ones with the current word.
// Result is registered: out_crc covers every word up to and including the previous cke cycle.
module jelly2_calc_crc #(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY_REPS  = 32'h04c11db7,
    parameter bit                   REVERSED   = 1'b0
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  logic                  in_update,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [CRC_WIDTH-1:0]  out_crc
);

    logic [CRC_WIDTH-1:0] r_crc;

    function automatic logic [CRC_WIDTH-1:0] calc_step(
        input logic [CRC_WIDTH-1:0]  crc,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [CRC_WIDTH-1:0] c;
        logic [CRC_WIDTH-1:0] poly_rev;
        logic                 fb;
        c = crc;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            poly_rev[i] = POLY_REPS[CRC_WIDTH-1-i];
        end
        // Reflected mode walks data LSB first against the bit-reversed polynomial.
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSED) begin
                fb = c[0] ^ data[i];
                c  = (c >> 1) ^ (fb ? poly_rev : '0);
            end else begin
                fb = c[CRC_WIDTH-1] ^ data[DATA_WIDTH-1-i];
                c  = (c << 1) ^ (fb ? POLY_REPS : '0);
            end
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc <= '1;
        end else if (cke) begin
            r_crc <= calc_step(in_update ? r_crc : '1, in_data);
        end
    end

    assign out_crc = r_crc;

endmodule

// File: rtl/jellyvl_etherneco_packet_rx.sv
// Etherneco frame receiver: parses header, streams payload and checks FCS; all outputs one cycle after the byte.
// No backpressure: the link pushes a byte on every s_rx_valid and payload beats are emitted unconditionally.
module jellyvl_etherneco_packet_rx
    import jellyvl_etherneco_packet_rx_pkg::*;
#(
    parameter logic [15:0] MAX_LENGTH = 16'hffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_rx_first,
    input  logic        s_rx_last,
    input  logic [7:0]  s_rx_data,
    input  logic        s_rx_valid,
    output logic        rx_start,
    output logic        rx_end,
    output logic        rx_error,
    output logic [15:0] rx_length,
    output logic [7:0]  rx_type,
    output logic [7:0]  rx_node,
    output logic        m_payload_first,
    output logic        m_payload_last,
    output logic [7:0]  m_payload_data,
    output logic        m_payload_valid
);

    localparam logic [1:0] LP_FCS_LAST = 2'(ETHERNECO_FCS_BYTES - 1);

    rx_state_t   r_state;
    logic [2:0]  r_pre_cnt;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_pay_cnt;
    logic [7:0]  r_len_lo;
    logic        r_fcs_err;
    logic [31:0] r_crc_hold;
    logic        r_start;
    logic        r_end;
    logic        r_error;
    logic [15:0] r_length;
    logic [7:0]  r_type;
    logic [7:0]  r_node;
    logic        r_pay_valid;
    logic        r_pay_first;
    logic        r_pay_last;
    logic [7:0]  r_pay_data;

    logic        w_crc_update;
    logic [31:0] w_crc;
    logic [7:0]  w_fcs_exp;
    logic        w_fcs_ng;
    logic        w_early_last;
    logic        w_first_abort;

    // The CRC register keeps absorbing FCS bytes, so it is snapshotted on FCS byte 0.
    assign w_crc_update  = !(r_state == ST_LENGTH && r_byte_cnt == 2'd0);
    assign w_fcs_exp     = (r_byte_cnt == 2'd0) ? w_crc[7:0]
                                                : 8'(r_crc_hold >> {r_byte_cnt, 3'b000});
    assign w_fcs_ng      = (s_rx_data != w_fcs_exp);
    assign w_early_last  = s_rx_last && !(r_state == ST_FCS && r_byte_cnt == LP_FCS_LAST);
    assign w_first_abort = (r_state != ST_IDLE) || (s_rx_last && s_rx_data == ETHERNECO_PREAMBLE);

    jelly2_calc_crc #(
        .DATA_WIDTH (8),
        .CRC_WIDTH  (32),
        .POLY_REPS  (ETHERNECO_CRC_POLY),
        .REVERSED   (1'b0)
    ) u_calc_crc (
        .reset      (rst),
        .clk        (clk),
        .cke        (s_rx_valid),
        .in_update  (w_crc_update),
        .in_data    (s_rx_data),
        .out_crc    (w_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pre_cnt   <= 3'd0;
            r_byte_cnt  <= 2'd0;
            r_pay_cnt   <= 16'd0;
            r_len_lo    <= 8'd0;
            r_fcs_err   <= 1'b0;
            r_crc_hold  <= 32'd0;
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_error     <= 1'b0;
            r_length    <= 16'd0;
            r_type      <= 8'd0;
            r_node      <= 8'd0;
            r_pay_valid <= 1'b0;
            r_pay_first <= 1'b0;
            r_pay_last  <= 1'b0;
            r_pay_data  <= 8'd0;
        end else begin
            r_start     <= 1'b0;
            r_end       <= 1'b0;
            r_error     <= 1'b0;
            r_pay_valid <= 1'b0;
            r_pay_first <= 1'b0;
            r_pay_last  <= 1'b0;
            if (s_rx_valid) begin
                if (s_rx_first) begin
                    r_end     <= w_first_abort;
                    r_error   <= w_first_abort;
                    r_state   <= (s_rx_data == ETHERNECO_PREAMBLE && !s_rx_last) ? ST_PREAMBLE : ST_IDLE;
                    r_pre_cnt <= 3'd1;
                end else if (w_early_last) begin
                    r_end   <= (r_state != ST_IDLE);
                    r_error <= (r_state != ST_IDLE);
                    r_state <= ST_IDLE;
                    if (r_state == ST_PAYLOAD) begin
                        r_pay_valid <= 1'b1;
                        r_pay_first <= (r_pay_cnt == r_length);
                        r_pay_last  <= 1'b1;
                        r_pay_data  <= s_rx_data;
                    end
                end else begin
                    case (r_state)
                        ST_PREAMBLE: begin
                            if (s_rx_data == ETHERNECO_PREAMBLE) begin
                                if (r_pre_cnt != 3'd7) r_pre_cnt <= r_pre_cnt + 3'd1;
                            end else if (s_rx_data == ETHERNECO_SFD && r_pre_cnt != 3'd0) begin
                                r_state    <= ST_LENGTH;
                                r_byte_cnt <= 2'd0;
                                r_start    <= 1'b1;
                            end else begin
                                r_state <= ST_ERROR;
                            end
                        end
                        ST_LENGTH: begin
                            if (r_byte_cnt == 2'd0) begin
                                r_len_lo   <= s_rx_data;
                                r_byte_cnt <= 2'd1;
                            end else begin
                                r_length <= {s_rx_data, r_len_lo};
                                r_state  <= ST_TYPE;
                            end
                        end
                        ST_TYPE: begin
                            r_type  <= s_rx_data;
                            r_state <= ST_NODE;
                        end
                        ST_NODE: begin
                            r_node    <= s_rx_data;
                            r_pay_cnt <= r_length;
                            r_state   <= (r_length > MAX_LENGTH) ? ST_ERROR : ST_PAYLOAD;
                        end
                        ST_PAYLOAD: begin
                            r_pay_valid <= 1'b1;
                            r_pay_first <= (r_pay_cnt == r_length);
                            r_pay_last  <= (r_pay_cnt == 16'd0);
                            r_pay_data  <= s_rx_data;
                            if (r_pay_cnt == 16'd0) begin
                                r_state    <= ST_FCS;
                                r_byte_cnt <= 2'd0;
                                r_fcs_err  <= 1'b0;
                            end else begin
                                r_pay_cnt <= r_pay_cnt - 16'd1;
                            end
                        end
                        ST_FCS: begin
                            if (r_byte_cnt == 2'd0) r_crc_hold <= w_crc;
                            r_fcs_err  <= r_fcs_err | w_fcs_ng;
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            if (r_byte_cnt == LP_FCS_LAST) begin
                                if (s_rx_last) begin
                                    r_end   <= 1'b1;
                                    r_error <= r_fcs_err | w_fcs_ng;
                                    r_state <= ST_IDLE;
                                end else begin
                                    r_state <= ST_ERROR;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign rx_start        = r_start;
    assign rx_end          = r_end;
    assign rx_error        = r_error;
    assign rx_length       = r_length;
    assign rx_type         = r_type;
    assign rx_node         = r_node;
    assign m_payload_first = r_pay_first;
    assign m_payload_last  = r_pay_last;
    assign m_payload_data  = r_pay_data;
    assign m_payload_valid = r_pay_valid;

endmodule

// File: tb/tb_jellyvl_etherneco_packet_rx.sv
// Directed bench for the etherneco receiver: a default instance and a MAX_LENGTH=15 instance share one byte stream.
module tb_jellyvl_etherneco_packet_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_rx_first;
    logic        s_rx_last;
    logic [7:0]  s_rx_data;
    logic        s_rx_valid;

    logic        rx_start, rx_end, rx_error;
    logic [15:0] rx_length;
    logic [7:0]  rx_type, rx_node;
    logic        m_payload_first, m_payload_last, m_payload_valid;
    logic [7:0]  m_payload_data;

    logic        x_start, x_end, x_error;
    logic [15:0] x_length;
    logic [7:0]  x_type, x_node;
    logic        x_first, x_last, x_valid;
    logic [7:0]  x_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fb  [0:127];
    int         fn;
    logic [7:0] pay [0:127];

    logic [7:0] b_dat   [0:8191];
    logic       b_first [0:8191];
    logic       b_last  [0:8191];
    logic       e_err   [0:511];
    logic       x_e_err [0:511];
    int n_beats = 0, n_start = 0, n_end = 0;
    int x_beats = 0, x_nstart = 0, x_nend = 0;

    always #5 clk = ~clk;

    jellyvl_etherneco_packet_rx dut (
        .clk(clk), .rst(rst),
        .s_rx_first(s_rx_first), .s_rx_last(s_rx_last), .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid),
        .rx_start(rx_start), .rx_end(rx_end), .rx_error(rx_error),
        .rx_length(rx_length), .rx_type(rx_type), .rx_node(rx_node),
        .m_payload_first(m_payload_first), .m_payload_last(m_payload_last),
        .m_payload_data(m_payload_data), .m_payload_valid(m_payload_valid)
    );

    jellyvl_etherneco_packet_rx #(.MAX_LENGTH(16'd15)) dut_max (
        .clk(clk), .rst(rst),
        .s_rx_first(s_rx_first), .s_rx_last(s_rx_last), .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid),
        .rx_start(x_start), .rx_end(x_end), .rx_error(x_error),
        .rx_length(x_length), .rx_type(x_type), .rx_node(x_node),
        .m_payload_first(x_first), .m_payload_last(x_last),
        .m_payload_data(x_data), .m_payload_valid(x_valid)
    );

    always @(negedge clk) begin
        if (rx_start) n_start = n_start + 1;
        if (m_payload_valid) begin
            if (n_beats < 8192) begin
                b_dat[n_beats]   = m_payload_data;
                b_first[n_beats] = m_payload_first;
                b_last[n_beats]  = m_payload_last;
            end
            n_beats = n_beats + 1;
        end
        if (rx_end) begin
            if (n_end < 512) e_err[n_end] = rx_error;
            n_end = n_end + 1;
        end
        if (x_start) x_nstart = x_nstart + 1;
        if (x_valid) x_beats = x_beats + 1;
        if (x_end) begin
            if (x_nend < 512) x_e_err[x_nend] = x_error;
            x_nend = x_nend + 1;
        end
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {d, 24'h0};
        for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        return r;
    endfunction

    task automatic make_frame(input int len, input logic [7:0] typ, input logic [7:0] node);
        logic [31:0] crc;
        logic [15:0] l16;
        l16 = 16'(len);
        fn  = 0;
        for (int i = 0; i < 7; i++) begin fb[fn] = 8'h55; fn++; end
        fb[fn] = 8'hD5;     fn++;
        fb[fn] = l16[7:0];  fn++;
        fb[fn] = l16[15:8]; fn++;
        fb[fn] = typ;       fn++;
        fb[fn] = node;      fn++;
        for (int i = 0; i <= len; i++) begin fb[fn] = pay[i]; fn++; end
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < fn; i++) crc = crc_byte(crc, fb[i]);
        for (int i = 0; i < 4; i++) begin fb[fn] = crc[8*i +: 8]; fn++; end
    endtask

    task automatic drive(input logic v, input logic f, input logic l, input logic [7:0] d);
        @(negedge clk);
        s_rx_valid = v; s_rx_first = f; s_rx_last = l; s_rx_data = d;
    endtask

    task automatic send_range(input int from, input int to, input bit gap);
        for (int i = from; i < to; i++) begin
            drive(1'b1, i == 0, i == fn - 1, fb[i]);
            if (gap) drive(1'b0, 1'b0, 1'b0, 8'h00);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_ends(input int target, output bit ok);
        int t;
        t = 0;
        while (n_end < target && t < 300) begin @(posedge clk); t++; end
        ok = (n_end >= target);
        repeat (4) @(posedge clk);
    endtask

    task automatic set_pay_a0;
        for (int i = 0; i < 4; i++) pay[i] = 8'hA0 + 8'(i);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++; if ({rx_start, rx_end, rx_error} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {rx_start, rx_end, rx_error}); end
        n_checks++; if ({m_payload_valid, m_payload_first, m_payload_last} !== 3'b000) begin n_fail++; $display("FAIL reset_payload: got %b want 000", {m_payload_valid, m_payload_first, m_payload_last}); end
        n_checks++; if ({rx_length, rx_type, rx_node} !== 32'h0) begin n_fail++; $display("FAIL reset_header: got %h want 0", {rx_length, rx_type, rx_node}); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_good(input string name, input bit gap);
        int s_st, s_en, s_bt;
        bit ok;
        set_pay_a0();
        make_frame(3, 8'h12, 8'h34);
        s_st = n_start; s_en = n_end; s_bt = n_beats;
        send_range(0, fn, gap);
        wait_ends(s_en + 1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_end: timeout, got %0d ends want 1", name, n_end - s_en); end
        n_checks++; if (n_start - s_st !== 1) begin n_fail++; $display("FAIL %s_start: got %0d want 1", name, n_start - s_st); end
        n_checks++; if (e_err[s_en] !== 1'b0) begin n_fail++; $display("FAIL %s_error: got %b want 0", name, e_err[s_en]); end
        n_checks++; if (n_beats - s_bt !== 4) begin n_fail++; $display("FAIL %s_beats: got %0d want 4", name, n_beats - s_bt); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({b_first[s_bt+i], b_last[s_bt+i], b_dat[s_bt+i]} !== {i == 0, i == 3, pay[i]}) begin
                n_fail++; $display("FAIL %s_beat%0d: got f%b l%b %h want f%b l%b %h", name, i,
                    b_first[s_bt+i], b_last[s_bt+i], b_dat[s_bt+i], i == 0, i == 3, pay[i]);
            end
        end
        n_checks++; if ({rx_length, rx_type, rx_node} !== {16'd3, 8'h12, 8'h34}) begin n_fail++; $display("FAIL %s_header: got %h want 00031234", name, {rx_length, rx_type, rx_node}); end
    endtask

    task automatic test_good_frame;
        run_good("good", 1'b0);
    endtask

    task automatic test_sparse;
        run_good("sparse", 1'b1);
    endtask

    task automatic test_fcs_error;
        int s_en, s_bt;
        bit ok;
        set_pay_a0();
        make_frame(3, 8'h12, 8'h34);
        fb[fn-2] = fb[fn-2] ^ 8'hFF;
        s_en = n_end; s_bt = n_beats;
        send_range(0, fn, 1'b0);
        wait_ends(s_en + 1, ok);
        n_checks++; if (!ok || e_err[s_en] !== 1'b1) begin n_fail++; $display("FAIL fcs_error: ends %0d err %b want 1 ends err 1", n_end - s_en, e_err[s_en]); end
        n_checks++; if (n_beats - s_bt !== 4) begin n_fail++; $display("FAIL fcs_beats: got %0d want 4", n_beats - s_bt); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (b_dat[s_bt+i] !== pay[i]) begin n_fail++; $display("FAIL fcs_beat%0d: got %h want %h", i, b_dat[s_bt+i], pay[i]); end
        end
    endtask

    task automatic test_cancel;
        int s_en, s_bt;
        bit ok;
        set_pay_a0();
        make_frame(3, 8'h12, 8'h34);
        fb[13] = 8'h00;
        fn     = 14;
        s_en = n_end; s_bt = n_beats;
        send_range(0, fn, 1'b0);
        wait_ends(s_en + 1, ok);
        n_checks++; if (!ok || e_err[s_en] !== 1'b1) begin n_fail++; $display("FAIL cancel_error: ends %0d err %b want 1 ends err 1", n_end - s_en, e_err[s_en]); end
        n_checks++; if (n_beats - s_bt !== 2) begin n_fail++; $display("FAIL cancel_beats: got %0d want 2", n_beats - s_bt); end
        n_checks++; if ({b_first[s_bt], b_last[s_bt], b_dat[s_bt]} !== {1'b1, 1'b0, 8'hA0}) begin n_fail++; $display("FAIL cancel_beat0: got %b%b %h want 10 a0", b_first[s_bt], b_last[s_bt], b_dat[s_bt]); end
        n_checks++; if ({b_first[s_bt+1], b_last[s_bt+1], b_dat[s_bt+1]} !== {1'b0, 1'b1, 8'h00}) begin n_fail++; $display("FAIL cancel_beat1: got %b%b %h want 01 00", b_first[s_bt+1], b_last[s_bt+1], b_dat[s_bt+1]); end
        run_good("after_cancel", 1'b0);
    endtask

    task automatic test_bad_preamble;
        int s_st, s_en, s_bt;
        bit ok;
        set_pay_a0();
        make_frame(3, 8'h12, 8'h34);
        fb[3] = 8'h57;
        s_st = n_start; s_en = n_end; s_bt = n_beats;
        send_range(0, fn, 1'b0);
        wait_ends(s_en + 1, ok);
        n_checks++; if (n_start - s_st !== 0) begin n_fail++; $display("FAIL pre_start: got %0d want 0", n_start - s_st); end
        n_checks++; if (!ok || e_err[s_en] !== 1'b1) begin n_fail++; $display("FAIL pre_error: ends %0d err %b want 1 ends err 1", n_end - s_en, e_err[s_en]); end
        n_checks++; if (n_beats - s_bt !== 0) begin n_fail++; $display("FAIL pre_beats: got %0d want 0", n_beats - s_bt); end
    endtask

    task automatic test_max_length;
        int s_en, s_bt, x_en, x_bt;
        bit ok;
        for (int i = 0; i < 17; i++) pay[i] = 8'h10 + 8'(i);
        make_frame(16, 8'h01, 8'h02);
        s_en = n_end; s_bt = n_beats; x_en = x_nend; x_bt = x_beats;
        send_range(0, fn, 1'b0);
        wait_ends(s_en + 1, ok);
        n_checks++; if (!ok || e_err[s_en] !== 1'b0 || n_beats - s_bt !== 17) begin n_fail++; $display("FAIL max_default: err %b beats %0d want 0 17", e_err[s_en], n_beats - s_bt); end
        n_checks++; if (x_beats - x_bt !== 0) begin n_fail++; $display("FAIL max_over_beats: got %0d want 0", x_beats - x_bt); end
        n_checks++; if (x_nend - x_en !== 1 || x_e_err[x_en] !== 1'b1) begin n_fail++; $display("FAIL max_over_error: ends %0d err %b want 1 1", x_nend - x_en, x_e_err[x_en]); end
        make_frame(15, 8'h01, 8'h02);
        s_en = n_end; x_en = x_nend; x_bt = x_beats;
        send_range(0, fn, 1'b0);
        wait_ends(s_en + 1, ok);
        n_checks++; if (x_beats - x_bt !== 16) begin n_fail++; $display("FAIL max_edge_beats: got %0d want 16", x_beats - x_bt); end
        n_checks++; if (x_nend - x_en !== 1 || x_e_err[x_en] !== 1'b0) begin n_fail++; $display("FAIL max_edge_error: ends %0d err %b want 1 0", x_nend - x_en, x_e_err[x_en]); end
        n_checks++; if (x_length !== 16'd15) begin n_fail++; $display("FAIL max_edge_length: got %0d want 15", x_length); end
    endtask

    task automatic test_first_mid;
        int s_st, s_en, s_bt;
        bit ok;
        set_pay_a0();
        make_frame(3, 8'h12, 8'h34);
        s_st = n_start; s_en = n_end; s_bt = n_beats;
        send_range(0, 11, 1'b0);
        send_range(0, fn, 1'b0);
        wait_ends(s_en + 2, ok);
        n_checks++; if (!ok || e_err[s_en] !== 1'b1 || e_err[s_en+1] !== 1'b0) begin n_fail++; $display("FAIL first_mid_ends: ends %0d errs %b%b want 2 10", n_end - s_en, e_err[s_en], e_err[s_en+1]); end
        n_checks++; if (n_start - s_st !== 2) begin n_fail++; $display("FAIL first_mid_start: got %0d want 2", n_start - s_st); end
        n_checks++; if (n_beats - s_bt !== 4) begin n_fail++; $display("FAIL first_mid_beats: got %0d want 4", n_beats - s_bt); end
    endtask

    task automatic test_reset_abort;
        int s_en;
        set_pay_a0();
        make_frame(3, 8'h12, 8'h34);
        s_en = n_end;
        send_range(0, 15, 1'b0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        n_checks++; if (n_end !== s_en) begin n_fail++; $display("FAIL abort_end: got %0d ends want 0", n_end - s_en); end
        n_checks++; if (rx_length !== 16'd0) begin n_fail++; $display("FAIL abort_length: got %0d want 0", rx_length); end
        run_good("after_reset", 1'b0);
    endtask

    task automatic test_loopback;
        int len, s_en, s_bt, bad;
        bit ok;
        logic [7:0] typ, node;
        for (int f = 0; f < 100; f++) begin
            len  = int'($urandom_range(0, 63));
            typ  = 8'($urandom);
            node = 8'($urandom);
            for (int i = 0; i <= len; i++) pay[i] = 8'($urandom);
            make_frame(len, typ, node);
            s_en = n_end; s_bt = n_beats;
            send_range(0, fn, 1'b0);
            wait_ends(s_en + 1, ok);
            n_checks++; if (!ok || e_err[s_en] !== 1'b0) begin n_fail++; $display("FAIL loop%0d_error: ends %0d err %b want 1 0", f, n_end - s_en, e_err[s_en]); end
            n_checks++; if (n_beats - s_bt !== len + 1) begin n_fail++; $display("FAIL loop%0d_beats: got %0d want %0d", f, n_beats - s_bt, len + 1); end
            bad = 0;
            for (int i = 0; i <= len; i++) begin
                if ({b_first[s_bt+i], b_last[s_bt+i], b_dat[s_bt+i]} !== {i == 0, i == len, pay[i]}) bad++;
            end
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL loop%0d_payload: %0d bad beats want 0", f, bad); end
            n_checks++; if ({rx_length, rx_type, rx_node} !== {16'(len), typ, node}) begin n_fail++; $display("FAIL loop%0d_header: got %h want %h", f, {rx_length, rx_type, rx_node}, {16'(len), typ, node}); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        s_rx_valid = 1'b0;
        s_rx_first = 1'b0;
        s_rx_last  = 1'b0;
        s_rx_data  = 8'h00;
        test_reset();
        test_good_frame();
        test_fcs_error();
        test_sparse();
        test_cancel();
        test_bad_preamble();
        test_max_length();
        test_first_mid();
        test_reset_abort();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
